// File: rtl/mips_alu_sched_if.sv
// Bundle of the two requester channels, the ALU drive/return bus and the
// response channel. The master side is the issue logic, the ALU and the
// response consumer together. The slave side is the scheduler.
interface mips_alu_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_ins;
  logic [31:0] req0_rega;
  logic [31:0] req0_regb;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_ins;
  logic [31:0] req1_rega;
  logic [31:0] req1_regb;
  logic [31:0] alu_ins;
  logic [31:0] alu_rega;
  logic [31:0] alu_regb;
  logic [31:0] alu_result;
  logic [2:0]  alu_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flag;

  modport master (
    output req0_valid, req0_ins, req0_rega, req0_regb,
    output req1_valid, req1_ins, req1_rega, req1_regb,
    input  req0_ready, req1_ready,
    input  alu_ins, alu_rega, alu_regb,
    output alu_result, alu_flag,
    input  rsp_valid, rsp_id, rsp_result, rsp_flag,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_ins, req0_rega, req0_regb,
    input  req1_valid, req1_ins, req1_rega, req1_regb,
    output req0_ready, req1_ready,
    output alu_ins, alu_rega, alu_regb,
    input  alu_result, alu_flag,
    output rsp_valid, rsp_id, rsp_result, rsp_flag,
    input  rsp_ready
  );
endinterface

// File: rtl/mips_alu_sched.sv
// Round-robin scheduler that shares one external combinational mips_alu
// between two requesters. An op is accepted, its operands are held on the
// ALU for ALU_LAT cycles, and then the result and flag are captured and
// returned with the id of the requester.
module mips_alu_sched #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_alu_sched_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_check
    $error("mips_alu_sched: ALU_LAT must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_gnt;
  logic [3:0]        cnt;
  logic              gnt;
  logic              hs;
  logic [1:0]        vld;
  logic [1:0]        rdy;
  logic [1:0][31:0]  ins, rega, regb;

  logic [31:0]       alu_ins_q, alu_rega_q, alu_regb_q;
  logic              rsp_valid_q, rsp_id_q;
  logic [31:0]       rsp_result_q;
  logic [2:0]        rsp_flag_q;
  logic [CNT_W-1:0]  ops_q;

  assign vld  = {bus.req1_valid, bus.req0_valid};
  assign ins  = {bus.req1_ins,   bus.req0_ins};
  assign rega = {bus.req1_rega,  bus.req0_rega};
  assign regb = {bus.req1_regb,  bus.req0_regb};
  assign hs   = |rdy;

  // Arbitration: under a tie the requester not granted last time wins.
  always_comb gnt = (&vld) ? ~last_gnt : vld[1];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept, hold for the ALU latency, then wait for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE for the granted requester; nothing during reset.
  always_comb begin
    rdy = 2'b00;
    if (rst_n && state == IDLE) begin
      rdy[0] = vld[0] && !gnt;
      rdy[1] = vld[1] && gnt;
    end
    busy = (state != IDLE);
  end

  // Datapath: operand latch, settle counter, result capture, completion count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_ins_q    <= '0;
      alu_rega_q   <= '0;
      alu_regb_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= '0;
      ops_q        <= '0;
      last_gnt     <= 1'b1;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          alu_ins_q  <= ins[gnt];
          alu_rega_q <= rega[gnt];
          alu_regb_q <= regb[gnt];
          rsp_id_q   <= gnt;
          last_gnt   <= gnt;
          cnt        <= 4'(ALU_LAT - 1);
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result_q <= bus.alu_result;
            rsp_flag_q   <= bus.alu_flag;
            rsp_valid_q  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          ops_q       <= ops_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.alu_ins    = alu_ins_q;
  assign bus.alu_rega   = alu_rega_q;
  assign bus.alu_regb   = alu_regb_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign ops_done       = ops_q;

endmodule
